// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a sync FIFO through a 2-entry skid buffer into a framed valid/ready stream; FIFO_RD_WDOG_EN adds a burst stall watchdog.
module fifo_burst_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_LEN   = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  burst_active,
  output logic                  stall_err
);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  if (BURST_LEN < 1 || WDOG_CYCLES < 2) begin : g_bad_params
    $error("fifo_burst_reader: BURST_LEN must be >= 1 and WDOG_CYCLES >= 2");
  end
  logic [DATA_WIDTH-1:0] head, tail;
  logic [1:0] occ;
  logic [2:0] level;
  logic [BW-1:0] beat_cnt;
  logic inflight, push, pop, state, wdog_fire;
  assign push = inflight;
  assign m_valid = occ != 2'd0;
  assign pop = m_valid && m_ready;
  assign m_data = head;
  assign m_last = m_valid && beat_cnt == LAST_BEAT;
  assign burst_active = state == BURST;
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  // flags lag one read, so a second back-to-back read needs at least two words
  assign fifo_rd_en = !rst && !fifo_empty && level < 3'd2 && (!inflight || !fifo_almost_empty);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ + {1'b0, push} - {1'b0, pop};
      if (pop) head <= (occ == 2'd2 || !push) ? tail : fifo_data;
      else if (push && occ == 2'd0) head <= fifo_data;
      if (push && (pop ? occ == 2'd2 : occ == 2'd1)) tail <= fifo_data;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      state    <= IDLE;
    end else if (wdog_fire) begin
      beat_cnt <= '0;
      state    <= IDLE;
    end else if (pop) begin
      beat_cnt <= m_last ? '0 : beat_cnt + BW'(1);
      state    <= m_last ? IDLE : BURST;
    end
  end
`ifdef FIFO_RD_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES);
  logic [WW-1:0] wdog_cnt;
  logic stall_q;
  assign wdog_fire = burst_active && !m_valid && wdog_cnt == WW'(WDOG_CYCLES - 1);
  assign stall_err = stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (pop || wdog_fire) wdog_cnt <= '0;
      else if (burst_active && !m_valid) wdog_cnt <= wdog_cnt + WW'(1);
      if (wdog_fire) stall_q <= 1'b1;
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign stall_err = 1'b0;
`endif
endmodule
